// File: rtl/neuron_accumulator.sv
// Neuron membrane accumulator: saturating sum of a frame, bias add, threshold fire.
// Optional NEURON_LEAK_EN: leaky integrate, next frame starts at sum>>1 or 0 after a spike.
module neuron_add16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum,
  output logic        o_co
);
  assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

module neuron_accumulator #(
  parameter int unsigned NUM_INPUTS = 8,
  parameter logic [15:0] THRESHOLD  = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [15:0] bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_fire,
  output logic        out_sat
);
  typedef enum logic [1:0] {
    S_ACCUM,
    S_BIAS,
    S_OUT
  } state_t;

  localparam logic [7:0] LAST = 8'(NUM_INPUTS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_acc;
  logic [7:0]  r_cnt;
  logic        r_sat;
  logic [15:0] r_sum;
  logic        r_fire;
  logic        r_osat;

  logic [15:0] w_b;
  logic [15:0] w_raw;
  logic        w_co;
  logic [15:0] w_sat_sum;
  logic        w_xfer;
  logic        w_last;
  logic [15:0] w_start;

  assign w_b = (r_state == S_BIAS) ? bias : in_data;

  neuron_add16 u_add (
    .i_a  (r_acc),
    .i_b  (w_b),
    .o_sum(w_raw),
    .o_co (w_co)
  );

  assign w_sat_sum = w_co ? 16'hFFFF : w_raw;
  assign in_ready  = (r_state == S_ACCUM);
  assign w_xfer    = in_valid & in_ready;
  assign w_last    = (r_cnt == LAST);
  assign out_valid = (r_state == S_OUT);
  assign out_sum   = r_sum;
  assign out_fire  = r_fire;
  assign out_sat   = r_osat;

`ifdef NEURON_LEAK_EN
  // Reset-after-spike, otherwise halve the previous membrane value
  assign w_start = r_fire ? 16'h0000 : {1'b0, r_sum[15:1]};
`else
  assign w_start = 16'h0000;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_ACCUM: if (w_xfer && w_last) w_next = S_BIAS;
      S_BIAS:  w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = S_ACCUM;
      default: w_next = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCUM;
      r_acc   <= 16'h0000;
      r_cnt   <= 8'd0;
      r_sat   <= 1'b0;
      r_sum   <= 16'h0000;
      r_fire  <= 1'b0;
      r_osat  <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_ACCUM: begin
          if (w_xfer) begin
            r_acc <= w_sat_sum;
            r_sat <= r_sat | w_co;
            r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
          end
        end
        S_BIAS: begin
          r_acc  <= w_sat_sum;
          r_sat  <= r_sat | w_co;
          r_sum  <= w_sat_sum;
          r_fire <= (w_sat_sum >= THRESHOLD);
          r_osat <= r_sat | w_co;
        end
        S_OUT: begin
          if (out_ready) begin
            r_acc <= w_start;
            r_sat <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator with a 4-beat frame.
module tb_neuron_accumulator;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_fire;
  logic        out_sat;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] start_v = 16'h0000;

  neuron_accumulator #(
    .NUM_INPUTS(4),
    .THRESHOLD (16'h0100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .bias     (bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_fire (out_fire),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  // d[0] is the first beat
  task automatic frame(input string tag, input logic [3:0][15:0] d,
                       input logic [15:0] b, input logic [15:0] exp_sum,
                       input logic exp_sat, input bit gaps, input int hold);
    logic [15:0] es;
    logic        esat;
    logic        ef;
    logic [16:0] t;
    int          w;
    es   = exp_sum;
    esat = exp_sat;
`ifdef NEURON_LEAK_EN
    es   = start_v;
    esat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t    = {1'b0, es} + {1'b0, (i < 4) ? d[i] : b};
      es   = t[16] ? 16'hFFFF : t[15:0];
      esat = esat | t[16];
    end
`endif
    ef = (es >= 16'h0100);
    bias = b;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = 16'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = d[i];
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w == 20) chk({tag, "_rdy_timeout"}, 0, 1);
      @(negedge clk);
    end
    in_valid = (hold > 0);
    in_data  = 16'h1234;
    chk({tag, "_bias_rdy"}, in_ready, 0);
    chk({tag, "_bias_vld"}, out_valid, 0);
    out_ready = (hold == 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_fire"}, out_fire, ef);
    chk({tag, "_sat"}, out_sat, esat);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk({tag, "_hold_vld"}, out_valid, 1);
        chk({tag, "_hold_rdy"}, in_ready, 0);
        chk({tag, "_hold_sum"}, out_sum, es);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
    chk({tag, "_vld_drop"}, out_valid, 0);
    chk({tag, "_next_rdy"}, in_ready, 1);
    chk({tag, "_sum_kept"}, out_sum, es);
`ifdef NEURON_LEAK_EN
    start_v = ef ? 16'h0000 : {1'b0, es[15:1]};
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 16'h0000;
    bias = 16'h0000;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_fire", out_fire, 0);
    chk("rst_sat", out_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1);

    frame("t1", {16'd4, 16'd3, 16'd2, 16'd1}, 16'd10, 16'd20, 1'b0, 0, 0);
    frame("t2", {16'h0000, 16'h0001, 16'h8000, 16'h8000}, 16'h0000,
          16'hFFFF, 1'b1, 0, 0);
    frame("bsat", {16'h0000, 16'h0000, 16'h0000, 16'hFFF0}, 16'h0020,
          16'hFFFF, 1'b1, 0, 0);
    frame("t3", {16'd4, 16'd3, 16'd2, 16'd1}, 16'd10, 16'd20, 1'b0, 0, 5);
    frame("t4", {16'd4, 16'd3, 16'd2, 16'd1}, 16'd10, 16'd20, 1'b0, 1, 0);
    frame("t4b", {16'd4, 16'd3, 16'd2, 16'd1}, 16'd10, 16'd20, 1'b0, 1, 0);
    frame("thr_fire", {16'h0000, 16'h0000, 16'h0080, 16'h0080}, 16'h0000,
          16'h0100, 1'b0, 0, 0);
    frame("l_80", {16'h0000, 16'h0000, 16'h0000, 16'h0080}, 16'h0000,
          16'h0080, 1'b0, 0, 0);
    frame("l_zero", {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000,
          16'h0000, 1'b0, 0, 0);
    frame("thr_ff", {16'h0000, 16'h0000, 16'h007F, 16'h0080}, 16'h0000,
          16'h00FF, 1'b0, 0, 0);
    frame("thr_fire2", {16'h0000, 16'h0000, 16'h0080, 16'h0080}, 16'h0000,
          16'h0100, 1'b0, 0, 0);
    frame("l_spike", {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000,
          16'h0000, 1'b0, 0, 0);

    in_valid = 1'b1;
    in_data  = 16'd5;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_vld", out_valid, 0);
    chk("t5_sum", out_sum, 0);
    chk("t5_fire", out_fire, 0);
    chk("t5_sat", out_sat, 0);
    start_v = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame("t5", {16'd1, 16'd1, 16'd1, 16'd1}, 16'd0, 16'd4, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
